fdct8_serial: RTL and testbench

- Forward 8-point 1-D DCT engine; the encode-side counterpart of the decoder's inverse-DCT basis path.
- Accepts 8 signed, level-shifted samples f(x) serially and produces the 8 coefficients F(u) serially, u = 0..7.
- Uses one shared multiply-accumulate unit over the signed 9-bit basis table T[x][u] = round(256·c(u)·cos((2x+1)uπ/16)).
- Row/column passes of a 2-D FDCT (JPEG encode or test-pattern generation) instantiate it twice with a transpose buffer between them.

---
 rtl/fdct_pkg.sv | 23 ++
 rtl/fdct8_serial_if.sv | 29 ++
 rtl/dct_basis_rom.sv | 39 +++
 rtl/fdct8_serial.sv | 123 ++++++++++++
 tb/tb_fdct8_serial.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fdct_pkg.sv
// rtl/fdct_pkg.sv - shared constants and state encoding for the serial 8-point FDCT
package fdct_pkg;

  // cos(k*pi/16) scaled by 256; the suffix is the cosine to four digits
  localparam logic [8:0] B_7071 = 9'd181;
  localparam logic [8:0] B_9807 = 9'd251;
  localparam logic [8:0] B_9238 = 9'd237;
  localparam logic [8:0] B_8314 = 9'd213;
  localparam logic [8:0] B_5555 = 9'd142;
  localparam logic [8:0] B_3826 = 9'd98;
  localparam logic [8:0] B_1950 = 9'd50;

  // Output scaling: 1/2 normalisation plus 256 table scale, rounding half up
  localparam int RND_ADD   = 256;
  localparam int RND_SHIFT = 9;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fdct8_serial_if.sv
// rtl/fdct8_serial_if.sv - sample-in / coefficient-out handshake bundle for fdct8_serial
interface fdct8_serial_if #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 11
);

  logic                    i_valid;
  logic                    o_ready;
  logic signed [IN_W-1:0]  i_data;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [OUT_W-1:0] o_data;
  logic [2:0]              o_index;
  logic                    o_last;
  logic                    o_busy;

  // Engine side
  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_index, o_last, o_busy
  );

  // Producer/consumer side
  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_index, o_last, o_busy
  );

endinterface

// File: rtl/dct_basis_rom.sv
// rtl/dct_basis_rom.sv - combinational 8x8 DCT basis table T[x][u]
module dct_basis_rom
  import fdct_pkg::*;
(
  input  logic [2:0]        x,
  input  logic [2:0]        u,
  output logic signed [8:0] t
);

  logic [4:0] k;
  logic [4:0] fold;
  logic [4:0] m;
  logic       neg;
  logic [8:0] mag;

  // Reduce the cosine phase (2x+1)u mod 32 to a first-quadrant index plus a sign
  always_comb begin
    k    = {1'b0, x, 1'b1} * {2'b00, u};
    fold = k[4] ? (5'd0 - k) : k;
    neg  = (fold > 5'd8);
    m    = neg ? (5'd16 - fold) : fold;
    case (m)
      5'd1:    mag = B_9807;
      5'd2:    mag = B_9238;
      5'd3:    mag = B_8314;
      5'd4:    mag = B_7071;
      5'd5:    mag = B_5555;
      5'd6:    mag = B_3826;
      5'd7:    mag = B_1950;
      default: mag = 9'd0;
    endcase
    if (u == 3'd0) begin
      t = B_7071;
    end else begin
      t = neg ? (9'd0 - mag) : mag;
    end
  end

endmodule

// File: rtl/fdct8_serial.sv
// rtl/fdct8_serial.sv - serial 8-point forward DCT with one shared MAC
module fdct8_serial
  import fdct_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 11
) (
  input logic           i_clk,
  input logic           i_arstn,
  fdct8_serial_if.slave bus
);

  localparam int ACC_W  = IN_W + 9 + 3;
  localparam int PROD_W = IN_W + 9;
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (OUT_W-1)));

  state_t                  state_q, state_d;
  logic [2:0]              x_cnt;
  logic [2:0]              u_cnt;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [IN_W-1:0]  sample_q [8];
  logic signed [OUT_W-1:0] o_data_q;

  logic signed [8:0]        basis;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd_shift;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     in_fire;
  logic                     out_fire;

  dct_basis_rom u_rom (
    .x (x_cnt),
    .u (u_cnt),
    .t (basis)
  );

  assign in_fire  = bus.i_valid && (state_q == LOAD);
  assign out_fire = bus.i_ready && (state_q == OUT);

  // MAC term, final rounding and clamp of the accumulated coefficient
  always_comb begin
    prod      = sample_q[x_cnt] * basis;
    acc_sum   = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    rnd_sum   = {acc_sum[ACC_W-1], acc_sum} + (ACC_W+1)'(RND_ADD);
    rnd_shift = rnd_sum >>> RND_SHIFT;
    if (rnd_shift > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (rnd_shift < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_val = rnd_shift[OUT_W-1:0];
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: 8 loads, then 8 MAC cycles and one output slot per coefficient
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && x_cnt == 3'd7) state_d = CALC;
      CALC:    if (x_cnt == 3'd7) state_d = OUT;
      OUT:     if (out_fire) state_d = (u_cnt == 3'd7) ? LOAD : CALC;
      default: state_d = LOAD;
    endcase
  end

  // Sample capture, accumulation and output register
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      x_cnt    <= 3'd0;
      u_cnt    <= 3'd0;
      acc_q    <= '0;
      o_data_q <= '0;
      for (int i = 0; i < 8; i++) sample_q[i] <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            sample_q[x_cnt] <= bus.i_data;
            x_cnt           <= x_cnt + 3'd1;
            if (x_cnt == 3'd7) begin
              u_cnt <= 3'd0;
              acc_q <= '0;
            end
          end
        end
        CALC: begin
          acc_q <= acc_sum;
          x_cnt <= x_cnt + 3'd1;
          if (x_cnt == 3'd7) o_data_q <= sat_val;
        end
        OUT: begin
          if (out_fire) begin
            acc_q <= '0;
            u_cnt <= u_cnt + 3'd1;
          end
        end
        default: begin
          x_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign bus.o_ready = (state_q == LOAD);
  assign bus.o_valid = (state_q == OUT);
  assign bus.o_busy  = (state_q != LOAD);
  assign bus.o_index = u_cnt;
  assign bus.o_last  = (state_q == OUT) && (u_cnt == 3'd7);
  assign bus.o_data  = o_data_q;

endmodule

// File: tb/tb_fdct8_serial.sv
// tb/tb_fdct8_serial.sv - self-checking bench for fdct8_serial against a cosine reference
module tb_fdct8_serial;

  localparam int  IN_W  = 9;
  localparam int  OUT_W = 11;
  localparam real PI    = 3.14159265358979;

  logic clk = 1'b0;
  logic arstn;

  always #5 clk = ~clk;

  fdct8_serial_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fdct8_serial #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .i_clk   (clk),
    .i_arstn (arstn),
    .bus     (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int smp  [8];
  int expv [8];
  int got  [8];

  task automatic check(input string tag, input int obs, input int expd);
    n_assert++;
    assert (obs === expd) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  function automatic int basis(input int x, input int u);
    real c, v;
    c = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 256.0 * c * $cos(real'((2 * x + 1) * u) * PI / 16.0);
    return int'($floor(v + 0.5));
  endfunction

  function automatic void compute_ref();
    int s, q, f;
    for (int u = 0; u < 8; u++) begin
      s = 0;
      for (int x = 0; x < 8; x++) s += smp[x] * basis(x, u);
      q = s + 256;
      f = (q >= 0) ? q / 512 : -((-q + 511) / 512);
      if (f >  (1 << (OUT_W - 1)) - 1) f = (1 << (OUT_W - 1)) - 1;
      if (f < -(1 << (OUT_W - 1)))     f = -(1 << (OUT_W - 1));
      expv[u] = f;
    end
  endfunction

  function automatic void random_block();
    for (int x = 0; x < 8; x++) smp[x] = int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic send_block(input string tag);
    int w;
    for (int x = 0; x < 8; x++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = IN_W'(smp[x]);
      w = 0;
      while (!bus.o_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("%s send x%0d ready", tag, x), int'(bus.o_ready), 1);
      @(posedge clk);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic recv_block(input string tag, input int stall_u, input int n);
    int w;
    for (int u = 0; u < n; u++) begin
      w = 0;
      while (!bus.o_valid && w < 200) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("%s u%0d valid", tag, u), int'(bus.o_valid), 1);
      check($sformatf("%s u%0d index", tag, u), int'(bus.o_index), u);
      check($sformatf("%s u%0d data", tag, u), int'(bus.o_data), expv[u]);
      check($sformatf("%s u%0d last", tag, u), int'(bus.o_last), (u == 7) ? 1 : 0);
      check($sformatf("%s u%0d ready", tag, u), int'(bus.o_ready), 0);
      check($sformatf("%s u%0d busy", tag, u), int'(bus.o_busy), 1);
      got[u] = int'(bus.o_data);
      if (u == stall_u) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check($sformatf("%s stall%0d valid", tag, s), int'(bus.o_valid), 1);
          check($sformatf("%s stall%0d index", tag, s), int'(bus.o_index), u);
          check($sformatf("%s stall%0d data", tag, s), int'(bus.o_data), got[u]);
          check($sformatf("%s stall%0d ready", tag, s), int'(bus.o_ready), 0);
        end
        bus.i_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (u + 1 == stall_u) bus.i_ready = 1'b0;
      if (u == 7) begin
        check($sformatf("%s ready after u7", tag), int'(bus.o_ready), 1);
        check($sformatf("%s busy after u7", tag), int'(bus.o_busy), 0);
      end
    end
  endtask

  initial begin
    int lat, d, pushed, nout, blocks, cyc;
    bit waiting, just_done;

    arstn       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    #1;
    check("reset o_ready", int'(bus.o_ready), 1);
    check("reset o_valid", int'(bus.o_valid), 0);
    check("reset o_data",  int'(bus.o_data), 0);
    check("reset o_index", int'(bus.o_index), 0);
    check("reset o_last",  int'(bus.o_last), 0);
    check("reset o_busy",  int'(bus.o_busy), 0);
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);

    // DC block with first-output latency
    for (int x = 0; x < 8; x++) smp[x] = 100;
    compute_ref();
    send_block("dc");
    check("dc ready drop", int'(bus.o_ready), 0);
    check("dc busy", int'(bus.o_busy), 1);
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("dc latency", lat, 8);
    recv_block("dc", -1, 8);
    check("dc F0", got[0], 283);
    check("dc F1", got[1], 0);
    check("dc F7", got[7], 0);

    // Impulse
    for (int x = 0; x < 8; x++) smp[x] = (x == 0) ? 127 : 0;
    compute_ref();
    send_block("imp");
    recv_block("imp", -1, 8);
    check("imp F0", got[0], 45);
    check("imp F1", got[1], 62);
    check("imp F4", got[4], 45);

    // Alternating sign
    for (int x = 0; x < 8; x++) smp[x] = (x % 2 == 0) ? 100 : -100;
    compute_ref();
    send_block("alt");
    recv_block("alt", -1, 8);
    check("alt F7", got[7], 256);
    check("alt F0", got[0], 0);
    check("alt F2", got[2], 0);
    check("alt F4", got[4], 0);
    check("alt F6", got[6], 0);

    // Random block with backpressure at u=3
    random_block();
    compute_ref();
    send_block("bp");
    recv_block("bp", 3, 8);

    // Extreme negative inputs
    for (int x = 0; x < 8; x++) smp[x] = -256;
    compute_ref();
    send_block("neg");
    recv_block("neg", -1, 8);
    check("neg F0", got[0], -724);

    // i_valid held high across two random blocks
    pushed    = 0;
    nout      = 0;
    blocks    = 0;
    cyc       = 0;
    waiting   = 1'b0;
    just_done = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    while (blocks < 2 && cyc < 400) begin
      if (just_done) begin
        check("cont ready back", int'(bus.o_ready), 1);
        just_done = 1'b0;
      end
      if (waiting) check("cont ready low", int'(bus.o_ready), 0);
      if (bus.o_valid) begin
        check($sformatf("cont b%0d u%0d index", blocks, nout), int'(bus.o_index), nout);
        check($sformatf("cont b%0d u%0d data", blocks, nout), int'(bus.o_data), expv[nout]);
        if (nout == 7) begin
          blocks++;
          nout      = 0;
          waiting   = 1'b0;
          just_done = 1'b1;
        end else begin
          nout++;
        end
      end
      d = int'($urandom_range(0, 511)) - 256;
      bus.i_data = IN_W'(d);
      if (bus.o_ready) begin
        smp[pushed] = d;
        pushed++;
        if (pushed == 8) begin
          compute_ref();
          pushed  = 0;
          waiting = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_valid = 1'b0;
    check("cont blocks", blocks, 2);
    @(negedge clk);

    // Reset during CALC of u=2, then a fresh block
    random_block();
    compute_ref();
    send_block("pre");
    recv_block("pre", -1, 2);
    repeat (3) @(negedge clk);
    arstn = 1'b0;
    #1;
    check("mid rst o_ready", int'(bus.o_ready), 1);
    check("mid rst o_valid", int'(bus.o_valid), 0);
    check("mid rst o_data",  int'(bus.o_data), 0);
    check("mid rst o_index", int'(bus.o_index), 0);
    check("mid rst o_last",  int'(bus.o_last), 0);
    check("mid rst o_busy",  int'(bus.o_busy), 0);
    @(negedge clk);
    arstn = 1'b1;
    @(negedge clk);
    random_block();
    compute_ref();
    send_block("post");
    recv_block("post", -1, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
